// File: rtl/struct_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : struct_pkg
//  Description : Shared definitions for the record summing stage: FSM state
//                encoding and record field offset/width helpers, also used
//                by the record producer stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package struct_pkg;

  // FSM state encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } state_t;

  // Tag occupies the low bits of a record
  localparam int c_TAG_LSB = 0;

  // Total packed record width: last flag + value + tag
  function automatic int rec_w(input int value_w, input int tag_w);
    return 1 + value_w + tag_w;
  endfunction

  // Value field sits directly above the tag
  function automatic int value_lsb(input int tag_w);
    return c_TAG_LSB + tag_w;
  endfunction

  // Last flag is the record MSB
  function automatic int last_bit(input int value_w, input int tag_w);
    return value_w + tag_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/struct_sum_unit.sv
`default_nettype none
// ============================================================================
//  Module      : struct_sum_unit
//  Description : Accumulates a group of tagged records (terminated by the
//                last flag) into a sum, record count and tag-mismatch flag,
//                then presents the result on a valid/ready output.
//  Revision    : 1.0 - initial release
// ============================================================================
module struct_sum_unit
  import struct_pkg::*;
#(
  parameter int VALUE_W = 32,
  parameter int TAG_W   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [VALUE_W+TAG_W:0]   in_rec,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [VALUE_W-1:0]       out_sum,
  output logic [TAG_W-1:0]         out_tag,
  output logic [TAG_W-1:0]         out_count,
  output logic                     out_err
);

  localparam int c_REC_W     = rec_w(VALUE_W, TAG_W);
  localparam int c_VALUE_LSB = value_lsb(TAG_W);
  localparam int c_LAST_BIT  = last_bit(VALUE_W, TAG_W);

  localparam logic [TAG_W-1:0] c_COUNT_MAX = '1;
  localparam logic [TAG_W-1:0] c_COUNT_ONE = TAG_W'(1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [VALUE_W-1:0]   r_sum;
  logic [TAG_W-1:0]     r_tag;
  logic [TAG_W-1:0]     r_count;
  logic                 r_err;

  logic [c_REC_W-1:0]   w_rec;
  logic                 w_last;
  logic [VALUE_W-1:0]   w_value;
  logic [TAG_W-1:0]     w_tag;
  logic                 w_accept;

  // Record field extraction
  assign w_rec    = in_rec;
  assign w_last   = w_rec[c_LAST_BIT];
  assign w_value  = w_rec[c_VALUE_LSB +: VALUE_W];
  assign w_tag    = w_rec[c_TAG_LSB +: TAG_W];

  // Input is blocked only while a result is waiting downstream
  assign in_ready = (r_state != EMIT);
  assign w_accept = in_valid && in_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: last record moves to EMIT, handshake returns to IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, ACCUM: begin
        if (w_accept) begin
          w_state_nxt = w_last ? EMIT : ACCUM;
        end
      end
      EMIT: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Accumulators: load on the first record of a group, accumulate afterwards
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sum   <= '0;
      r_tag   <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      if (r_state == IDLE) begin
        r_sum   <= w_value;
        r_tag   <= w_tag;
        r_count <= c_COUNT_ONE;
        r_err   <= 1'b0;
      end else begin
        // Sum wraps naturally; count sticks at its maximum
        r_sum   <= r_sum + w_value;
        r_count <= (r_count == c_COUNT_MAX) ? r_count : r_count + c_COUNT_ONE;
        r_err   <= r_err | (w_tag != r_tag);
      end
    end
  end

  // Result outputs always reflect the live accumulators
  assign out_valid = (r_state == EMIT);
  assign out_sum   = r_sum;
  assign out_tag   = r_tag;
  assign out_count = r_count;
  assign out_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_struct_sum_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_struct_sum_unit
//  Description : Self-checking bench for struct_sum_unit with an expected
//                result queue filled as groups are driven.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_struct_sum_unit;

  typedef struct packed {
    logic [31:0] sum;
    logic [7:0]  tag;
    logic [7:0]  cnt;
    logic        err;
  } res_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [40:0] in_rec;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic [7:0]  out_tag;
  logic [7:0]  out_count;
  logic        out_err;

  int   n_cmp = 0;
  int   n_bad = 0;
  res_t exp_q[$];

  struct_sum_unit #(.VALUE_W(32), .TAG_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rec    (in_rec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_tag   (out_tag),
    .out_count (out_count),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  // Drive one record from a negedge and return at the negedge after acceptance
  task automatic send_rec(input bit last, input logic [31:0] v, input logic [7:0] t);
    int k;
    k = 0;
    in_valid = 1'b1;
    in_rec   = {last, v, t};
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL send_rec_ready: in_ready=%b required 1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for a result, capture it, then complete the handshake
  task automatic get_result(output res_t r, output bit to);
    int k;
    k  = 0;
    to = 1'b0;
    while (!out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (out_valid !== 1'b1) begin
      to = 1'b1;
      r  = '0;
    end else begin
      r = {out_sum, out_tag, out_count, out_err};
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    n_cmp++;
    if ({out_sum, out_tag, out_count, out_err} !== 49'd0) begin
      n_bad++;
      $display("FAIL reset_regs: got sum=%h tag=%h cnt=%h err=%b required all 0", out_sum, out_tag, out_count, out_err);
    end
  endtask

  task automatic test_basic();
    res_t r, e;
    bit   to;
    send_rec(1'b0, 32'd100, 8'd10);
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_mid_valid: got %b required 0", out_valid); end
    send_rec(1'b1, 32'd50, 8'd10);
    exp_q.push_back('{sum: 32'd150, tag: 8'd10, cnt: 8'd2, err: 1'b0});
    n_cmp++;
    if (out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_latency: out_valid=%b required 1", out_valid); end
    get_result(r, to);
    e = exp_q.pop_front();
    n_cmp++;
    if (to || r !== e) begin
      n_bad++;
      $display("FAIL basic_result: got sum=%h tag=%h cnt=%h err=%b timeout=%b required sum=%h tag=%h cnt=%h err=%b",
               r.sum, r.tag, r.cnt, r.err, to, e.sum, e.tag, e.cnt, e.err);
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_post_hs: out_valid=%b required 0", out_valid); end
  endtask

  task automatic test_wrap();
    res_t r, e;
    bit   to;
    send_rec(1'b0, 32'hFFFF_FFF0, 8'd3);
    send_rec(1'b1, 32'h0000_0020, 8'd3);
    exp_q.push_back('{sum: 32'h10, tag: 8'd3, cnt: 8'd2, err: 1'b0});
    get_result(r, to);
    e = exp_q.pop_front();
    n_cmp++;
    if (to || r !== e) begin
      n_bad++;
      $display("FAIL wrap_result: got sum=%h tag=%h cnt=%h err=%b timeout=%b required sum=%h tag=%h cnt=%h err=%b",
               r.sum, r.tag, r.cnt, r.err, to, e.sum, e.tag, e.cnt, e.err);
    end
  endtask

  task automatic test_err();
    res_t r, e;
    bit   to;
    send_rec(1'b0, 32'd1, 8'd5);
    send_rec(1'b0, 32'd2, 8'd6);
    send_rec(1'b1, 32'd3, 8'd5);
    exp_q.push_back('{sum: 32'd6, tag: 8'd5, cnt: 8'd3, err: 1'b1});
    get_result(r, to);
    e = exp_q.pop_front();
    n_cmp++;
    if (to || r !== e) begin
      n_bad++;
      $display("FAIL err_result: got sum=%h tag=%h cnt=%h err=%b timeout=%b required sum=%h tag=%h cnt=%h err=%b",
               r.sum, r.tag, r.cnt, r.err, to, e.sum, e.tag, e.cnt, e.err);
    end
  endtask

  task automatic test_backpressure();
    res_t r, e;
    bit   to;
    send_rec(1'b1, 32'd42, 8'd7);
    exp_q.push_back('{sum: 32'd42, tag: 8'd7, cnt: 8'd1, err: 1'b0});
    // Offer a new record while the result is held back
    in_valid  = 1'b1;
    in_rec    = {1'b1, 32'd5, 8'd9};
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL bp_hold_%0d: in_ready=%b out_valid=%b required 0/1", i, in_ready, out_valid);
      end
      r = {out_sum, out_tag, out_count, out_err};
      n_cmp++;
      if (r !== exp_q[0]) begin
        n_bad++;
        $display("FAIL bp_stable_%0d: got sum=%h tag=%h cnt=%h err=%b required sum=%h tag=%h cnt=%h err=%b",
                 i, r.sum, r.tag, r.cnt, r.err, exp_q[0].sum, exp_q[0].tag, exp_q[0].cnt, exp_q[0].err);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    e = exp_q.pop_front();
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_to_idle: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
    // The still-pending record is taken on this edge
    exp_q.push_back('{sum: 32'd5, tag: 8'd9, cnt: 8'd1, err: 1'b0});
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_next_accept: out_valid=%b required 1", out_valid); end
    get_result(r, to);
    e = exp_q.pop_front();
    n_cmp++;
    if (to || r !== e) begin
      n_bad++;
      $display("FAIL bp_result: got sum=%h tag=%h cnt=%h err=%b timeout=%b required sum=%h tag=%h cnt=%h err=%b",
               r.sum, r.tag, r.cnt, r.err, to, e.sum, e.tag, e.cnt, e.err);
    end
  endtask

  task automatic test_reset_mid();
    res_t r, e;
    bit   to;
    send_rec(1'b0, 32'd7, 8'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 32'd0) begin
      n_bad++;
      $display("FAIL rstmid_clear: out_valid=%b in_ready=%b sum=%h required 0/1/0", out_valid, in_ready, out_sum);
    end
    send_rec(1'b1, 32'd9, 8'd2);
    exp_q.push_back('{sum: 32'd9, tag: 8'd2, cnt: 8'd1, err: 1'b0});
    get_result(r, to);
    e = exp_q.pop_front();
    n_cmp++;
    if (to || r !== e) begin
      n_bad++;
      $display("FAIL rstmid_result: got sum=%h tag=%h cnt=%h err=%b timeout=%b required sum=%h tag=%h cnt=%h err=%b",
               r.sum, r.tag, r.cnt, r.err, to, e.sum, e.tag, e.cnt, e.err);
    end
    // Reset while a result is pending discards it
    send_rec(1'b1, 32'd3, 8'd3);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || out_count !== 8'd0) begin
      n_bad++;
      $display("FAIL rstemit_discard: out_valid=%b cnt=%h required 0/0", out_valid, out_count);
    end
  endtask

  task automatic test_saturate();
    res_t r, e;
    bit   to;
    int   cnt;
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      if (cnt < 255) cnt++;
      send_rec(i == 299, 32'd1, 8'd4);
    end
    exp_q.push_back('{sum: 32'd300, tag: 8'd4, cnt: 8'(cnt), err: 1'b0});
    get_result(r, to);
    e = exp_q.pop_front();
    n_cmp++;
    if (to || r !== e) begin
      n_bad++;
      $display("FAIL sat_result: got sum=%h tag=%h cnt=%h err=%b timeout=%b required sum=%h tag=%h cnt=%h err=%b",
               r.sum, r.tag, r.cnt, r.err, to, e.sum, e.tag, e.cnt, e.err);
    end
  endtask

  task automatic test_random();
    res_t r, e, m;
    bit   to;
    int   len;
    logic [7:0]  tag0, t;
    logic [31:0] v;
    for (int g = 0; g < 6; g++) begin
      len  = $urandom_range(1, 5);
      tag0 = 8'($urandom);
      m    = '{sum: 32'd0, tag: tag0, cnt: 8'd0, err: 1'b0};
      for (int i = 0; i < len; i++) begin
        v = $urandom;
        t = (i > 0 && $urandom_range(0, 3) == 0) ? (tag0 ^ 8'h01) : tag0;
        m.sum = m.sum + v;
        m.cnt = m.cnt + 8'd1;
        if (t != tag0) m.err = 1'b1;
        send_rec(i == len - 1, v, t);
      end
      exp_q.push_back(m);
      get_result(r, to);
      e = exp_q.pop_front();
      n_cmp++;
      if (to || r !== e) begin
        n_bad++;
        $display("FAIL rand_result_%0d: got sum=%h tag=%h cnt=%h err=%b timeout=%b required sum=%h tag=%h cnt=%h err=%b",
                 g, r.sum, r.tag, r.cnt, r.err, to, e.sum, e.tag, e.cnt, e.err);
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_rec    = '0;
    out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_wrap();
    test_err();
    test_backpressure();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
